// File: rtl/capture_ctrl.sv
// capture_ctrl: arm/trigger/post-count sequencer for a logic-analyser capture
// buffer. It latches the trigger configuration on arm and streams the
// (one-cycle delayed) probe into a circular buffer. On a trigger hit it
// records the trigger address and then writes exactly cfg_post more samples
// before stopping in DONE.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   arm, abort          start / cancel pulses (abort wins)
//   cfg_value/mask/mode trigger configuration, latched on an accepted arm
//   cfg_post            post-trigger sample count, latched on an accepted arm
//   probe_data          live probe bus
//   trigger_hit         registered hit; it refers to the sample in wr_data
//   trig_value/mask/mode latched configuration driving the trigger unit
//   wr_en/wr_addr/wr_data buffer write port
//   trig_addr           buffer address of the trigger sample
//   wrapped             pre-trigger history has filled the buffer
//   busy, done          state decodes (ARMED|CAPTURE, DONE)
module capture_ctrl #(
  parameter  int PROBE_W = 8,
  parameter  int DEPTH   = 16,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic [PROBE_W-1:0] cfg_value,
  input  logic [PROBE_W-1:0] cfg_mask,
  input  logic [1:0]         cfg_mode,
  input  logic [ADDR_W-1:0]  cfg_post,
  input  logic [PROBE_W-1:0] probe_data,
  input  logic               trigger_hit,
  output logic [PROBE_W-1:0] trig_value,
  output logic [PROBE_W-1:0] trig_mask,
  output logic [1:0]         trig_mode,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PROBE_W-1:0] wr_data,
  output logic [ADDR_W-1:0]  trig_addr,
  output logic               wrapped,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PROBE_W-1:0] probe_q, probe_d;
  logic [PROBE_W-1:0] value_q, value_d;
  logic [PROBE_W-1:0] mask_q, mask_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  post_q, post_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [ADDR_W-1:0]  taddr_q, taddr_d;
  logic [ADDR_W-1:0]  remain_q, remain_d;
  logic               wrapped_q, wrapped_d;
  logic               holdoff_q, holdoff_d;
  logic               writing;
  logic               hit;

  always_comb begin
    probe_d   = probe_data;
    state_d   = state_q;
    value_d   = value_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    post_d    = post_q;
    waddr_d   = waddr_q;
    taddr_d   = taddr_q;
    remain_d  = remain_q;
    wrapped_d = wrapped_q;
    // holdoff_q is high only for the first ARMED cycle: the hit seen then
    // was computed against the configuration in force before the arm.
    holdoff_d = 1'b0;

    writing = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    hit     = (state_q == S_ARMED) && trigger_hit && !holdoff_q;

    // The write happens whenever we are streaming, even on an abort cycle.
    if (writing) begin
      waddr_d = waddr_q + ADDR_W'(1);
      if ((state_q == S_ARMED) && (&waddr_q)) wrapped_d = 1'b1;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            value_d   = cfg_value;
            mask_d    = cfg_mask;
            mode_d    = cfg_mode;
            post_d    = cfg_post;
            waddr_d   = '0;
            taddr_d   = '0;
            wrapped_d = 1'b0;
            holdoff_d = 1'b1;
            state_d   = S_ARMED;
          end
        end
        S_ARMED: begin
          if (hit) begin
            // trigger sample is the one being written this cycle
            taddr_d  = waddr_q;
            remain_d = post_q;
            state_d  = (post_q == '0) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      probe_q   <= '0;
      value_q   <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      post_q    <= '0;
      waddr_q   <= '0;
      taddr_q   <= '0;
      remain_q  <= '0;
      wrapped_q <= 1'b0;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      probe_q   <= probe_d;
      value_q   <= value_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      post_q    <= post_d;
      waddr_q   <= waddr_d;
      taddr_q   <= taddr_d;
      remain_q  <= remain_d;
      wrapped_q <= wrapped_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign trig_value = value_q;
  assign trig_mask  = mask_q;
  assign trig_mode  = mode_q;
  assign wr_en      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign wr_addr    = waddr_q;
  assign wr_data    = probe_q;
  assign trig_addr  = taddr_q;
  assign wrapped    = wrapped_q;
  assign busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done       = (state_q == S_DONE);

endmodule
